// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is the ALU, bit 1 the LSU; after
// reset the ALU is favoured because the pointer claims the LSU was served last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_r;  // 1: requester 1 won the most recent grant

  // Grant selection: a lone requester always wins, contention goes to the other side of last_r
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_r ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer moves only when something is actually granted
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (gnt != 2'b00) begin
      last_r <= gnt[1];
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and per-register busy scoreboard in front of the single
// register-array write port. Register 0 is never busy and is never written.
module regfile_wb_sched #(
  parameter int WIDTH   = 32,
  parameter int REG_NUM = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iss_valid,
  input  logic               iss_wen,
  input  logic [4:0]         iss_rd,
  input  logic [4:0]         iss_rs1,
  input  logic [4:0]         iss_rs2,
  output logic               iss_ready,
  input  logic               alu_valid,
  input  logic [4:0]         alu_rd,
  input  logic [WIDTH-1:0]   alu_data,
  output logic               alu_ready,
  input  logic               lsu_valid,
  input  logic [4:0]         lsu_rd,
  input  logic [WIDTH-1:0]   lsu_data,
  output logic               lsu_ready,
  output logic               rf_wen,
  output logic [4:0]         rf_waddr,
  output logic [WIDTH-1:0]   rf_wdata,
  output logic [REG_NUM-1:0] busy,
  output logic               err
);

  localparam int AW = 5;

  logic [REG_NUM-1:0] busy_r;
  logic               rf_wen_r;
  logic [AW-1:0]      rf_waddr_r;
  logic [WIDTH-1:0]   rf_wdata_r;
  logic               err_r;

  logic [1:0]         gnt_s;
  logic               grant_s;
  logic [AW-1:0]      g_rd_s;
  logic [WIDTH-1:0]   g_data_s;
  logic               g_legal_s;
  logic               g_busy_s;
  logic               grant_err_s;
  logic               rs1_busy_s;
  logic               rs2_busy_s;
  logic               rd_busy_s;
  logic               iss_ready_s;
  logic               issue_fire_s;
  logic               issue_ill_s;
  logic               issue_err_s;
  logic [REG_NUM-1:0] set_mask_s;
  logic [REG_NUM-1:0] clr_mask_s;
  logic [REG_NUM-1:0] x0_mask_s;

  // One-hot decode of a register index; out-of-range indices decode to nothing
  function automatic logic [REG_NUM-1:0] dec(input logic [AW-1:0] idx);
    logic [REG_NUM-1:0] m;
    m = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      m[i] = (idx == AW'(i));
    end
    return m;
  endfunction

  function automatic logic legal(input logic [AW-1:0] idx);
    return (32'(idx) < REG_NUM);
  endfunction

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({lsu_valid, alu_valid}),
    .gnt (gnt_s)
  );

  assign alu_ready = gnt_s[0];
  assign lsu_ready = gnt_s[1];
  assign grant_s   = gnt_s[0] | gnt_s[1];
  assign x0_mask_s = {{(REG_NUM-1){1'b1}}, 1'b0};

  // Granted write-back payload mux
  always_comb begin
    g_rd_s   = alu_rd;
    g_data_s = alu_data;
    if (gnt_s[1]) begin
      g_rd_s   = lsu_rd;
      g_data_s = lsu_data;
    end else begin
      g_rd_s   = alu_rd;
      g_data_s = alu_data;
    end
  end

  // Hazard check and scoreboard update masks; x0 is masked out of every lookup
  always_comb begin
    rs1_busy_s   = |(busy_r & x0_mask_s & dec(iss_rs1));
    rs2_busy_s   = |(busy_r & x0_mask_s & dec(iss_rs2));
    rd_busy_s    = |(busy_r & x0_mask_s & dec(iss_rd));
    iss_ready_s  = !rs1_busy_s && !rs2_busy_s && !(iss_wen && rd_busy_s);
    issue_fire_s = iss_valid && iss_ready_s;
    issue_ill_s  = !legal(iss_rs1) || !legal(iss_rs2) || (iss_wen && !legal(iss_rd));
    issue_err_s  = issue_fire_s && issue_ill_s;
    g_legal_s    = legal(g_rd_s);
    g_busy_s     = |(busy_r & x0_mask_s & dec(g_rd_s));
    grant_err_s  = grant_s && (!g_legal_s || (g_rd_s != 5'd0 && !g_busy_s));
    if (issue_fire_s && iss_wen && !issue_ill_s && iss_rd != 5'd0) begin
      set_mask_s = dec(iss_rd);
    end else begin
      set_mask_s = '0;
    end
    if (rf_wen_r) begin
      clr_mask_s = dec(rf_waddr_r);
    end else begin
      clr_mask_s = '0;
    end
  end

  // Scoreboard, write stage and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r     <= '0;
      rf_wen_r   <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= '0;
      err_r      <= 1'b0;
    end else begin
      busy_r <= ((busy_r & ~clr_mask_s) | set_mask_s) & x0_mask_s;
      // x0 and illegal destinations are accepted but never reach the array
      if (grant_s && g_rd_s != 5'd0 && g_legal_s) begin
        rf_wen_r   <= 1'b1;
        rf_waddr_r <= g_rd_s;
        rf_wdata_r <= g_data_s;
      end else begin
        rf_wen_r   <= 1'b0;
        rf_waddr_r <= rf_waddr_r;
        rf_wdata_r <= rf_wdata_r;
      end
      if (grant_err_s || issue_err_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign iss_ready = iss_ready_s;
  assign rf_wen    = rf_wen_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_wen;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] busy;
  logic        err;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  regfile_wb_sched #(.WIDTH(32), .REG_NUM(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_wen   (iss_wen),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_ready (iss_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge (one rising edge passes)
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_wen = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Issue one writing instruction with no sources for a single cycle
  task automatic issue_rd(input logic [4:0] rd);
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = rd; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    step();
    iss_valid = 1'b0; iss_wen = 1'b0; iss_rd = 5'd0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();

    // Reset then idle
    do_reset();
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wen", 32'(rf_wen), 32'h0);
    chk("rst_waddr", 32'(rf_waddr), 32'h0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_ready", 32'(iss_ready), 32'h1);

    // RAW stall and release
    step();
    issue_rd(5'd5);
    #1;
    chk("raw_busy5", 32'(busy), 32'h0020);
    iss_valid = 1'b1; iss_wen = 1'b0; iss_rs1 = 5'd5;
    #1;
    chk("raw_stall", 32'(iss_ready), 32'h0);
    iss_rs1 = 5'd0; iss_wen = 1'b1; iss_rd = 5'd5;
    #1;
    chk("waw_stall", 32'(iss_ready), 32'h0);
    iss_wen = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    chk("raw_alu_rdy", 32'(alu_ready), 32'h1);
    chk("raw_lsu_rdy", 32'(lsu_ready), 32'h0);
    step();
    alu_valid = 1'b0;
    #1;
    chk("raw_n1_wen", 32'(rf_wen), 32'h1);
    chk("raw_n1_addr", 32'(rf_waddr), 32'd5);
    chk("raw_n1_data", rf_wdata, 32'hDEADBEEF);
    chk("raw_n1_stall", 32'(iss_ready), 32'h0);
    step();
    #1;
    chk("raw_n2_wen", 32'(rf_wen), 32'h0);
    chk("raw_n2_busy", 32'(busy), 32'h0);
    chk("raw_n2_ready", 32'(iss_ready), 32'h1);
    chk("raw_n2_hold", rf_wdata, 32'hDEADBEEF);
    chk("raw_err", 32'(err), 32'h0);

    // Contention: ALU first after reset, then alternate while both stay valid
    do_reset();
    issue_rd(5'd3);
    issue_rd(5'd4);
    issue_rd(5'd6);
    #1;
    chk("ct_busy", 32'(busy), 32'h0058);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    #1;
    chk("ct_c0_alu", 32'({lsu_ready, alu_ready}), 32'b01);
    step();
    alu_rd = 5'd6; alu_data = 32'h66;
    #1;
    chk("ct_c1_lsu", 32'({lsu_ready, alu_ready}), 32'b10);
    chk("ct_c1_wr", 32'({rf_wen, rf_waddr}), 32'h23);
    chk("ct_c1_data", rf_wdata, 32'h33);
    step();
    lsu_valid = 1'b0;
    #1;
    chk("ct_c2_alu", 32'({lsu_ready, alu_ready}), 32'b01);
    chk("ct_c2_wr", 32'({rf_wen, rf_waddr}), 32'h24);
    chk("ct_c2_data", rf_wdata, 32'h44);
    step();
    alu_valid = 1'b0;
    #1;
    chk("ct_c3_rdy", 32'({lsu_ready, alu_ready}), 32'b00);
    chk("ct_c3_wr", 32'({rf_wen, rf_waddr}), 32'h26);
    step();
    #1;
    chk("ct_busy_end", 32'(busy), 32'h0);
    chk("ct_err", 32'(err), 32'h0);

    // x0 handling
    do_reset();
    issue_rd(5'd0);
    #1;
    chk("x0_busy", 32'(busy), 32'h0);
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
    #1;
    chk("x0_lsu_rdy", 32'(lsu_ready), 32'h1);
    step();
    lsu_valid = 1'b0;
    #1;
    chk("x0_wen", 32'(rf_wen), 32'h0);
    chk("x0_wdata", rf_wdata, 32'h0);
    chk("x0_err", 32'(err), 32'h0);

    // Write-back to a register that is not busy
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    #1;
    chk("e7_alu_rdy", 32'(alu_ready), 32'h1);
    step();
    alu_valid = 1'b0;
    #1;
    chk("e7_err", 32'(err), 32'h1);
    step();
    step();
    step();
    #1;
    chk("e7_sticky", 32'(err), 32'h1);
    do_reset();
    #1;
    chk("e7_clr", 32'(err), 32'h0);

    // Illegal source index at issue
    iss_valid = 1'b1; iss_rs2 = 5'd20;
    #1;
    chk("e20_ready", 32'(iss_ready), 32'h1);
    step();
    iss_valid = 1'b0; iss_rs2 = 5'd0;
    #1;
    chk("e20_err", 32'(err), 32'h1);

    // Illegal destination at issue sets no busy bit
    do_reset();
    issue_rd(5'd16);
    #1;
    chk("e16_err", 32'(err), 32'h1);
    chk("e16_busy", 32'(busy), 32'h0);

    // Reset right after a write to register 2 is granted
    do_reset();
    issue_rd(5'd2);
    issue_rd(5'd9);
    #1;
    chk("mr_busy", 32'(busy), 32'h0204);
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    #1;
    chk("mr_alu_rdy", 32'(alu_ready), 32'h1);
    rst = 1'b1;
    step();
    alu_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mr_busy0", 32'(busy), 32'h0);
    chk("mr_wen0", 32'(rf_wen), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      chk("mr_nowrite", 32'(rf_wen), 32'h0);
    end
    chk("mr_err", 32'(err), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
